wbc_lclk: RTL

Wishbone line-time clock (KW11-L class) for the VM1 system. Divides the 1 ms system strobe from the reset/clock controller into a periodic line-clock event and exposes it through a CSR at 177546. It raises a vectored interrupt request into the VIC with an ireq/iack pair. With the counter option compiled in, it also keeps a 16-bit tick counter at 177544.

---
 rtl/wbc_lclk_pkg.sv | 25 ++
 rtl/wbc_lclk_presc.sv | 28 ++
 rtl/wbc_lclk.sv | 118 +++++++++++
 3 files changed

// File: rtl/wbc_lclk_pkg.sv
// Shared constants and types for the wbc_lclk line-time clock (KW11-L class).
// Offsets, CSR bit positions, the CSR read mask and a byte-lane merge helper.
package wbc_lclk_pkg;

    localparam logic [1:0]  LCLK_OFS_CNT  = 2'd0;
    localparam logic [1:0]  LCLK_OFS_CSR  = 2'd2;
    localparam int          LCLK_MON      = 7;
    localparam int          LCLK_IE       = 6;
    localparam logic [15:0] LCLK_CSR_MASK = 16'o000300;

    typedef struct packed {
        logic mon;
        logic ie;
        logic pend;
    } lclk_csr_t;

    function automatic logic [15:0] lclk_merge(input logic [15:0] old_v,
                                               input logic [15:0] new_v,
                                               input logic [1:0]  sel);
        lclk_merge = old_v;
        if (sel[0]) lclk_merge[7:0]  = new_v[7:0];
        if (sel[1]) lclk_merge[15:8] = new_v[15:8];
    endfunction

endpackage

// File: rtl/wbc_lclk_presc.sv
// Free-running 1 ms strobe prescaler; tick_o is combinational so the CSR and
// interrupt logic can act on the same edge that samples the wrapping strobe.
module wbc_lclk_presc
    import wbc_lclk_pkg::*;
#(
    parameter int PERIOD_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena_ms_i,
    output logic tick_o
);

    logic [7:0] r_cnt;
    logic       w_wrap;

    assign w_wrap = (r_cnt == 8'(PERIOD_MS - 1));
    assign tick_o = ena_ms_i & w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (ena_ms_i) begin
            r_cnt <= w_wrap ? 8'd0 : r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/wbc_lclk.sv
// Wishbone line-time clock: CSR at offset 2, optional tick counter at offset 0
// built only when CONFIG_WBC_LCLK_COUNTER_EN is defined.
module wbc_lclk
    import wbc_lclk_pkg::*;
#(
    parameter int PERIOD_MS = 20
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        init_i,
    input  logic        ena_ms_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        irq_o,
    input  logic        iack_i
);

    logic        w_tick;
    logic        w_req;
    logic        w_wr;
    logic        w_wr_csr;
    logic        r_ack;
    logic [15:0] r_dat;
    logic [15:0] w_rd_val;
    logic [15:0] w_csr_rd;
    logic [15:0] w_cnt_rd;
    lclk_csr_t   r_csr;
    lclk_csr_t   w_csr_nxt;

    wbc_lclk_presc #(.PERIOD_MS(PERIOD_MS)) u_presc (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n),
        .ena_ms_i (ena_ms_i),
        .tick_o   (w_tick)
    );

    assign w_req    = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr     = w_req & wb_we_i;
    assign w_wr_csr = w_wr & (wb_adr_i == LCLK_OFS_CSR) & wb_sel_i[0];

    // Order matters: write IE, then tick forces MON, then pend uses the new IE.
    always_comb begin
        w_csr_nxt = r_csr;
        if (init_i) begin
            w_csr_nxt = '0;
        end else begin
            if (w_wr_csr) begin
                w_csr_nxt.ie = wb_dat_i[LCLK_IE];
                if (!wb_dat_i[LCLK_MON]) w_csr_nxt.mon = 1'b0;
            end
            if (w_tick) w_csr_nxt.mon = 1'b1;
            if (!w_csr_nxt.ie)
                w_csr_nxt.pend = 1'b0;
            else if (w_tick || (!r_csr.ie && w_csr_nxt.mon))
                w_csr_nxt.pend = 1'b1;
            else if (iack_i)
                w_csr_nxt.pend = 1'b0;
        end
    end

    assign w_csr_rd = {8'h00, r_csr.mon, r_csr.ie, 6'h00} & LCLK_CSR_MASK;

`ifdef CONFIG_WBC_LCLK_COUNTER_EN
    logic [15:0] r_cnt;
    logic        w_wr_cnt;

    assign w_wr_cnt = w_wr & (wb_adr_i == LCLK_OFS_CNT) & (|wb_sel_i);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_cnt <= '0;
        end else if (w_wr_cnt) begin
            r_cnt <= lclk_merge(r_cnt, wb_dat_i, wb_sel_i);
        end else if (w_tick) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign w_cnt_rd = r_cnt;
`else
    logic w_unused;

    assign w_cnt_rd = '0;
    assign w_unused = ^{wb_dat_i[15:8], wb_dat_i[5:0], wb_sel_i[1]};
`endif

    always_comb begin
        w_rd_val = '0;
        case (wb_adr_i)
            LCLK_OFS_CNT: w_rd_val = w_cnt_rd;
            LCLK_OFS_CSR: w_rd_val = w_csr_rd;
            default:      w_rd_val = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_csr <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req & ~wb_we_i) ? w_rd_val : 16'h0000;
            r_csr <= w_csr_nxt;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign irq_o    = r_csr.pend;

endmodule
